// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file: combinational reads, synchronous writes,
// optional write forwarding, x0 shadow for dummy instructions and write-error flag.
module ibex_register_file_mp #(
  parameter bit                   RV32E             = 1'b0,
  parameter int                   DataWidth         = 32,
  parameter int                   NumReadPorts      = 2,
  parameter int                   NumWritePorts     = 1,
  parameter bit                   WriteForward      = 1'b0,
  parameter bit                   DummyInstructions = 1'b0,
  parameter bit                   WrenCheck         = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal       = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              dummy_instr_id_i,
  input  logic                              dummy_instr_wb_i,
  input  logic [5*NumReadPorts-1:0]         raddr_i,
  output logic [DataWidth*NumReadPorts-1:0] rdata_o,
  input  logic [NumWritePorts-1:0]          we_i,
  input  logic [5*NumWritePorts-1:0]        waddr_i,
  input  logic [DataWidth*NumWritePorts-1:0] wdata_i,
  output logic                              err_o
);

  localparam int NumWords = RV32E ? 16 : 32;
  localparam int IdxW     = RV32E ? 4 : 5;

  // Word 0 of the array is the x0 shadow; it stays zero without dummy instructions.
  logic [DataWidth-1:0] rf_q [NumWords];
  logic [DataWidth-1:0] rf_d [NumWords];
  logic                 err_q, err_d;

  logic [4:0]               waddr [NumWritePorts];
  logic [DataWidth-1:0]     wdata [NumWritePorts];
  logic [NumWritePorts-1:0] we_eff;
  logic [NumWritePorts-1:0] w_oor;
  logic                     we_shadow;

  logic [4:0]           raddr [NumReadPorts];
  logic [DataWidth-1:0] rdata [NumReadPorts];

  always_comb begin
    for (int p = 0; p < NumWritePorts; p++) begin
      waddr[p]  = waddr_i[5*p +: 5];
      wdata[p]  = wdata_i[DataWidth*p +: DataWidth];
      w_oor[p]  = RV32E && waddr[p][4];
      we_eff[p] = we_i[p] && (waddr[p] != 5'd0) && !w_oor[p];
    end
  end

  assign we_shadow = DummyInstructions && dummy_instr_wb_i && we_i[0] &&
                     (waddr_i[4:0] == 5'd0);

  // Ports applied in ascending order so the highest-indexed port wins a conflict.
  always_comb begin
    rf_d = rf_q;
    if (!DummyInstructions) begin
      rf_d[0] = '0;
    end else if (we_shadow) begin
      rf_d[0] = wdata[0];
    end
    for (int p = 0; p < NumWritePorts; p++) begin
      if (we_eff[p]) begin
        rf_d[waddr[p][IdxW-1:0]] = wdata[p];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NumReadPorts; k++) begin
      raddr[k] = raddr_i[5*k +: 5];
      if (RV32E && raddr[k][4]) begin
        rdata[k] = '0;
      end else if (raddr[k] == 5'd0) begin
        rdata[k] = (DummyInstructions && dummy_instr_id_i) ? rf_q[0] : WordZeroVal;
      end else begin
        rdata[k] = rf_q[raddr[k][IdxW-1:0]];
        if (WriteForward) begin
          for (int p = 0; p < NumWritePorts; p++) begin
            if (we_eff[p] && (waddr[p] == raddr[k])) begin
              rdata[k] = wdata[p];
            end
          end
        end
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < NumReadPorts; k++) begin
      rdata_o[DataWidth*k +: DataWidth] = rdata[k];
    end
  end

  always_comb begin
    err_d = 1'b0;
    for (int p = 0; p < NumWritePorts; p++) begin
      if (we_i[p] && w_oor[p]) begin
        err_d = 1'b1;
      end
      for (int q = p + 1; q < NumWritePorts; q++) begin
        if (we_i[p] && we_i[q] && (waddr[p] == waddr[q]) && (waddr[p] != 5'd0)) begin
          err_d = 1'b1;
        end
      end
    end
    if (!WrenCheck) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rf_q  <= '{default: '0};
      err_q <= 1'b0;
    end else begin
      rf_q  <= rf_d;
      err_q <= err_d;
    end
  end

  assign err_o = WrenCheck ? err_q : 1'b0;

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Directed bench: one RV32E instance without forwarding and one RV32I instance
// with forwarding, both 2R/2W with dummy shadow and error checking, on shared stimulus.
module tb_ibex_register_file_mp;

  localparam logic [31:0] Wzv = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dummy_id, dummy_wb;
  logic [9:0]  raddr;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [63:0] rdata_e, rdata_f;
  logic        err_e, err_f;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  ibex_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteForward(1'b0), .DummyInstructions(1'b1), .WrenCheck(1'b1), .WordZeroVal(Wzv)
  ) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
    .raddr_i(raddr), .rdata_o(rdata_e), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .err_o(err_e)
  );

  ibex_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
    .WriteForward(1'b1), .DummyInstructions(1'b1), .WrenCheck(1'b1), .WordZeroVal(Wzv)
  ) dut_f (
    .clk_i(clk), .rst_ni(rst_n), .dummy_instr_id_i(dummy_id), .dummy_instr_wb_i(dummy_wb),
    .raddr_i(raddr), .rdata_o(rdata_f), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .err_o(err_f)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] en, input logic [4:0] a0, input logic [31:0] d0,
                    input logic [4:0] a1, input logic [31:0] d1);
    we    = en;
    waddr = {a1, a0};
    wdata = {d1, d0};
  endtask

  task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
    raddr = {r1, r0};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; dummy_id = 1'b0; dummy_wb = 1'b0; raddr = '0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick(); tick();
    rst_n = 1'b1;

    // reset state
    rd(5'd5, 5'd0);
    check_eq("rst_x5_e", rdata_e[31:0], 32'h0);
    check_eq("rst_x5_f", rdata_f[31:0], 32'h0);
    check_eq("rst_x0_e", rdata_e[63:32], Wzv);
    check_eq("rst_x0_f", rdata_f[63:32], Wzv);
    check_eq("rst_err_e", err_e, 1'b0);
    check_eq("rst_err_f", err_f, 1'b0);

    // basic write / read, forwarding in the write cycle
    wr(2'b01, 5'd7, 32'hDEADBEEF, 5'd0, 32'h0);
    rd(5'd0, 5'd7);
    check_eq("wr_cycle_x7_e", rdata_e[63:32], 32'h0);
    check_eq("wr_cycle_x7_f", rdata_f[63:32], 32'hDEADBEEF);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(5'd0, 5'd7);
    check_eq("after_wr_x7_e", rdata_e[63:32], 32'hDEADBEEF);
    check_eq("after_wr_x7_f", rdata_f[63:32], 32'hDEADBEEF);

    // overwrite via port 1: old value without forwarding
    wr(2'b10, 5'd0, 32'h0, 5'd7, 32'hCAFEF00D);
    rd(5'd7, 5'd0);
    check_eq("ovr_cycle_x7_e", rdata_e[31:0], 32'hDEADBEEF);
    check_eq("ovr_cycle_x7_f", rdata_f[31:0], 32'hCAFEF00D);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(5'd7, 5'd0);
    check_eq("ovr_x7_e", rdata_e[31:0], 32'hCAFEF00D);
    check_eq("ovr_x7_f", rdata_f[31:0], 32'hCAFEF00D);
    check_eq("ovr_err_e", err_e, 1'b0);

    // dual-write conflict
    wr(2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
    rd(5'd3, 5'd0);
    check_eq("conf_cycle_x3_e", rdata_e[31:0], 32'h0);
    check_eq("conf_cycle_x3_f", rdata_f[31:0], 32'h22);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(5'd3, 5'd0);
    check_eq("conf_x3_e", rdata_e[31:0], 32'h22);
    check_eq("conf_x3_f", rdata_f[31:0], 32'h22);
    check_eq("conf_err_e", err_e, 1'b1);
    check_eq("conf_err_f", err_f, 1'b1);
    tick();
    check_eq("conf_err_drop_e", err_e, 1'b0);
    check_eq("conf_err_drop_f", err_f, 1'b0);

    // back-to-back conflicts keep err high
    wr(2'b11, 5'd2, 32'h33, 5'd2, 32'h44);
    tick();
    check_eq("hold_err_1_e", err_e, 1'b1);
    wr(2'b11, 5'd2, 32'h55, 5'd2, 32'h66);
    tick();
    check_eq("hold_err_2_e", err_e, 1'b1);
    check_eq("hold_err_2_f", err_f, 1'b1);
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    check_eq("hold_err_end_e", err_e, 1'b0);
    rd(5'd2, 5'd0);
    check_eq("hold_x2_e", rdata_e[31:0], 32'h66);
    check_eq("hold_x2_f", rdata_f[31:0], 32'h66);

    // x0 shadow for dummy instructions, never forwarded
    dummy_id = 1'b1; dummy_wb = 1'b1;
    wr(2'b01, 5'd0, 32'h55, 5'd0, 32'h0);
    rd(5'd0, 5'd0);
    check_eq("shadow_cycle_e", rdata_e[31:0], 32'h0);
    check_eq("shadow_cycle_f", rdata_f[31:0], 32'h0);
    tick();
    dummy_wb = 1'b0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(5'd0, 5'd0);
    check_eq("shadow_rd_e", rdata_e[31:0], 32'h55);
    check_eq("shadow_rd_f", rdata_f[31:0], 32'h55);
    check_eq("shadow_err_e", err_e, 1'b0);
    dummy_id = 1'b0;
    rd(5'd0, 5'd0);
    check_eq("x0_nodummy_e", rdata_e[31:0], Wzv);
    check_eq("x0_nodummy_f", rdata_f[31:0], Wzv);
    wr(2'b01, 5'd0, 32'h77, 5'd0, 32'h0);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    dummy_id = 1'b1;
    rd(5'd0, 5'd0);
    check_eq("x0_plain_wr_e", rdata_e[31:0], 32'h55);
    dummy_wb = 1'b1;
    wr(2'b10, 5'd0, 32'h0, 5'd0, 32'h88);
    tick();
    dummy_wb = 1'b0;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(5'd0, 5'd0);
    check_eq("x0_port1_dummy_e", rdata_e[31:0], 32'h55);
    check_eq("x0_port1_dummy_f", rdata_f[31:0], 32'h55);
    dummy_id = 1'b0;

    // RV32E range; x20 aliases x4 in its low four bits
    wr(2'b01, 5'd4, 32'h1234, 5'd0, 32'h0);
    tick();
    wr(2'b10, 5'd0, 32'h0, 5'd20, 32'h99);
    rd(5'd20, 5'd4);
    check_eq("oor_cycle_x20_e", rdata_e[31:0], 32'h0);
    check_eq("oor_cycle_x20_f", rdata_f[31:0], 32'h99);
    tick();
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    rd(5'd20, 5'd4);
    check_eq("oor_x20_e", rdata_e[31:0], 32'h0);
    check_eq("oor_x4_e", rdata_e[63:32], 32'h1234);
    check_eq("oor_x20_f", rdata_f[31:0], 32'h99);
    check_eq("oor_x4_f", rdata_f[63:32], 32'h1234);
    check_eq("oor_err_e", err_e, 1'b1);
    check_eq("oor_err_f", err_f, 1'b0);
    tick();
    check_eq("oor_err_drop_e", err_e, 1'b0);

    // reset in the middle of writes with an error pending
    wr(2'b11, 5'd10, 32'h1, 5'd10, 32'h2);
    tick();
    rst_n = 1'b0;
    wr(2'b11, 5'd9, 32'hAB, 5'd9, 32'hAB);
    rd(5'd9, 5'd7);
    check_eq("rst_pending_err_e", err_e, 1'b1);
    tick();
    rst_n = 1'b1;
    wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    dummy_id = 1'b1;
    rd(5'd9, 5'd7);
    check_eq("rstmid_x9_e", rdata_e[31:0], 32'h0);
    check_eq("rstmid_x9_f", rdata_f[31:0], 32'h0);
    check_eq("rstmid_x7_e", rdata_e[63:32], 32'h0);
    check_eq("rstmid_err_e", err_e, 1'b0);
    check_eq("rstmid_err_f", err_f, 1'b0);
    rd(5'd0, 5'd2);
    check_eq("rstmid_shadow_e", rdata_e[31:0], 32'h0);
    check_eq("rstmid_x2_f", rdata_f[63:32], 32'h0);
    dummy_id = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
